// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: baud strobe, rx_done synchroniser, one-capture-per-frame FSM and host FIFO.
// Optional macro UART_RX_DROP_BAD_EN: parity-bad frames are counted but never queued.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int IS_PARITY  = 0,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   baud_div,
    output logic                          rx_tick,
    input  logic                          rx_done,
    input  logic [DATA_BITS-1:0]          rx_dout,
    input  logic                          correct,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic [CNT_W-1:0]              parity_err_cnt,
    input  logic                          clr_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_OFF, S_ARMED, S_CAPTURE, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [15:0]          div_cnt_q, div_cnt_d;
    logic [2:0]           sync_q, sync_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    logic done_s, done_rise, capture, bad, keep, push, pop, lost;

    // Baud generator: a stale count above a newly lowered baud_div wraps without a tick.
    always_comb begin
        div_cnt_d = '0;
        rx_tick   = 1'b0;
        if (enable && baud_div != 16'd0) begin
            if (div_cnt_q == baud_div) begin
                rx_tick   = 1'b1;
                div_cnt_d = '0;
            end else if (div_cnt_q > baud_div) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
            end
        end
    end

    // sync_q[1] is done_s; sync_q[2] is its previous value. The chain resets to 1 so a
    // frame still pending when reset releases is treated as already seen.
    assign sync_d    = {sync_q[1:0], rx_done};
    assign done_s    = sync_q[1];
    assign done_rise = sync_q[1] && !sync_q[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF:     if (enable) state_d = S_ARMED;
            S_ARMED:   if (!enable) state_d = S_OFF;
                       else if (done_rise) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_HOLD;
            S_HOLD:    if (!done_s) state_d = enable ? S_ARMED : S_OFF;
            default:   state_d = S_OFF;
        endcase
    end

    always_comb begin
        capture = (state_q == S_CAPTURE);
    end

    assign empty = (count_q == CW'(0));
    assign full  = (count_q == CW'(FIFO_DEPTH));

    always_comb begin
        bad = (IS_PARITY != 0) && !correct;
`ifdef UART_RX_DROP_BAD_EN
        keep = !bad;
`else
        keep = 1'b1;
`endif
        pop  = rd_en && !empty;
        // A pop in the same cycle frees the slot even when the FIFO is full.
        push = capture && keep && (!full || rd_en);
        lost = capture && keep && full && !rd_en;

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_data_d = pop  ? mem[rd_ptr_q] : rd_data_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overrun_d = overrun_q;
        if (lost) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end

        err_d = err_q;
        if (capture && bad) begin
            if (clr_status) begin
                err_d = CNT_W'(1);
            end else if (err_q != '1) begin
                err_d = err_q + CNT_W'(1);
            end
        end else if (clr_status) begin
            err_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            sync_q    <= '1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            overrun_q <= 1'b0;
            err_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sync_q    <= sync_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
        end
    end

    // NOTE: FIFO storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rx_dout;
        end
    end

    assign count          = count_q;
    assign rd_data        = rd_data_q;
    assign overrun        = overrun_q;
    assign parity_err_cnt = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a queue scoreboard of expected FIFO contents.
// Honours UART_RX_DROP_BAD_EN when computing expectations for parity-bad frames.
module tb_uart_rx_ctrl;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 8;
`ifdef UART_RX_DROP_BAD_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic [15:0]          baud_div = 16'd0;
    logic                 rx_tick;
    logic                 rx_done = 1'b0;
    logic [DATA_BITS-1:0] rx_dout = '0;
    logic                 correct = 1'b1;
    logic                 rd_en = 1'b0;
    logic [DATA_BITS-1:0] rd_data;
    logic                 empty, full;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                 overrun;
    logic [CNT_W-1:0]     parity_err_cnt;
    logic                 clr_status = 1'b0;

    uart_rx_ctrl #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IS_PARITY (1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .baud_div      (baud_div),
        .rx_tick       (rx_tick),
        .rx_done       (rx_done),
        .rx_dout       (rx_dout),
        .correct       (correct),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overrun       (overrun),
        .parity_err_cnt(parity_err_cnt),
        .clr_status    (clr_status)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [DATA_BITS-1:0] sb_q[$];
    logic [DATA_BITS-1:0] last_rd = '0;
    bit                   m_ovr = 1'b0;
    int                   m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, 32'(count), 32'(sb_q.size()));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_perr"}, 32'(parity_err_cnt), 32'(m_err));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tick"}, 32'(rx_tick), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
        check({tag, "_perr"}, 32'(parity_err_cnt), 32'd0);
    endtask

    // One complete frame; rd/clr are asserted exactly in the capture cycle
    // (rx_done rises, two sync flops, one ARMED cycle, then CAPTURE).
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic c,
                              input logic rd, input logic clr);
        logic [DATA_BITS-1:0] exp;
        bit bad, keep, was_full;
        bad      = !c;
        keep     = !(bad && DROP);
        was_full = (sb_q.size() == FIFO_DEPTH);
        @(negedge clk);
        rx_dout = d;
        correct = c;
        rx_done = 1'b1;
        repeat (3) @(negedge clk);
        rd_en      = rd;
        clr_status = clr;
        @(negedge clk);
        rd_en      = 1'b0;
        clr_status = 1'b0;
        if (rd && sb_q.size() > 0) begin
            exp     = sb_q.pop_front();
            last_rd = exp;
            check("rd_coincident", 32'(rd_data), 32'(exp));
        end
        if (keep && was_full && !rd) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (keep && (!was_full || rd)) sb_q.push_back(d);
        if (bad) m_err = clr ? 1 : (m_err < 255 ? m_err + 1 : 255);
        else if (clr) m_err = 0;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic read_one();
        logic [DATA_BITS-1:0] exp;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (sb_q.size() > 0) begin
            exp     = sb_q.pop_front();
            last_rd = exp;
            check("rd_data", 32'(rd_data), 32'(exp));
        end else begin
            check("rd_hold_empty", 32'(rd_data), 32'(last_rd));
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        m_ovr = 1'b0;
        m_err = 0;
    endtask

    initial begin
        int n_ticks, gap_bad, last_tick;

        // Reset state
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Baud generator: baud_div=3 -> one tick every 4 clocks
        baud_div = 16'd3;
        enable   = 1'b1;
        n_ticks = 0; gap_bad = 0; last_tick = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rx_tick) begin
                n_ticks++;
                if (last_tick >= 0 && i - last_tick != 4) gap_bad++;
                last_tick = i;
            end
        end
        check("tick_count_div3", 32'(n_ticks), 32'd10);
        check("tick_period_div3", 32'(gap_bad), 32'd0);

        baud_div = 16'd0;
        n_ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_tick) n_ticks++;
        end
        check("tick_div0", 32'(n_ticks), 32'd0);

        baud_div = 16'd3;
        enable   = 1'b0;
        n_ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_tick) n_ticks++;
        end
        check("tick_disabled", 32'(n_ticks), 32'd0);
        baud_div = 16'd0;
        enable   = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame held long: exactly one push, then pop
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        check("single_count", 32'(count), 32'd1);
        check("single_empty", 32'(empty), 32'd0);
        read_one();
        check("single_empty_after", 32'(empty), 32'd1);

        // Fill to full, then overrun on the 17th
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
            if (i == 14) check("full_at_15", 32'(full), 32'd0);
        end
        check("full_at_16", 32'(full), 32'd1);
        check("count_16", 32'(count), 32'd16);
        check("no_ovr_16", 32'(overrun), 32'd0);
        send_frame(8'hEE, 1'b1, 1'b0, 1'b0);
        check("ovr_17", 32'(overrun), 32'd1);
        check("count_17", 32'(count), 32'd16);

        // Coincident pop with a capture into a full FIFO: no overrun
        pulse_clr();
        check("clr_ovr", 32'(overrun), 32'd0);
        send_frame(8'h77, 1'b1, 1'b1, 1'b0);
        check("coinc_ovr", 32'(overrun), 32'd0);
        check("coinc_count", 32'(count), 32'd16);
        check_model("coinc");

        while (sb_q.size() > 0) read_one();
        check("drained_empty", 32'(empty), 32'd1);

        // rd_en while empty
        read_one();
        check("empty_rd_count", 32'(count), 32'd0);

        // Parity errors
        for (int i = 0; i < 3; i++) send_frame(8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        check("perr_3", 32'(parity_err_cnt), 32'd3);
        check("perr_count", 32'(count), DROP ? 32'd0 : 32'd3);
        send_frame(8'hB3, 1'b0, 1'b0, 1'b1);
        check("perr_clr_event", 32'(parity_err_cnt), 32'd1);
        check_model("perr");

        // Saturation
        for (int i = 0; i < 300; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("perr_sat", 32'(parity_err_cnt), 32'd255);
        check_model("sat");
        pulse_clr();
        while (sb_q.size() > 0) read_one();
        read_one();
        check_model("sat_drain");

        // Reset in HOLD with count=5 and overrun=1
        for (int i = 0; i < 17; i++) send_frame(8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        repeat (12) read_one();
        @(negedge clk);
        rx_dout = 8'h3C;
        correct = 1'b1;
        rx_done = 1'b1;
        sb_q.push_back(8'h3C);
        repeat (6) @(negedge clk);
        check("pre_reset_count", 32'(count), 32'd5);
        check("pre_reset_ovr", 32'(overrun), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        m_ovr = 1'b0;
        m_err = 0;
        last_rd = '0;
        repeat (10) @(negedge clk);
        check("stale_done_count", 32'(count), 32'd0);
        rx_done = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check("after_reset_count", 32'(count), 32'd1);
        read_one();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
